// File: rtl/piso_shift_tx_if.sv
// ---------------------------------------------------------------------------
// piso_shift_tx_if
// Load handshake and serial output bundle for the piso_shift_tx transmitter.
//
// Signals:
//   din        WIDTH  parallel word offered for transmission
//   load_valid 1      din is valid this cycle
//   load_ready 1      transmitter can accept a word
//   sout       1      serial data out, MSB first, idle level 0
//   busy       1      frame bits are on sout
//   done       1      one-cycle pulse after the last bit
//
// Modports:
//   master  word producer (drives din/load_valid, observes the rest)
//   slave   the transmitter
// ---------------------------------------------------------------------------
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output load_valid,
        input  load_ready,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load_valid,
        output load_ready,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in, serial-out transmitter with clock enable. Accepts one WIDTH-bit
// word through a valid/ready handshake and shifts it out MSB first, one bit
// per enabled clock, then pulses done for one (enabled) cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides en
//   en   clock enable; 0 holds all state and outputs
//   bus  piso_shift_tx_if.slave: din, load_valid, load_ready, sout, busy, done
//
// Build option:
//   PISO_PARITY_EN  when defined, an even-parity bit (^din of the accepted
//                   word) follows the WIDTH data bits.
// ---------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    piso_shift_tx_if.slave        bus
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] NBITS_C = CNT_W'(NBITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_r;
    // Holds the bits still to be sent after the one currently on sout.
    logic [NBITS-2:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;
    logic [NBITS-1:0] frame;

`ifdef PISO_PARITY_EN
    // Parity is taken from the word captured at accept, not from later din.
    assign frame = {bus.din, ^bus.din};
`else
    assign frame = bus.din;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
            sout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else if (en) begin
            case (state_r)
                ST_IDLE: begin
                    // din is only looked at here, so X on it elsewhere is harmless.
                    if (bus.load_valid && ready_r) begin
                        shreg_r <= frame[NBITS-2:0];
                        sout_r  <= frame[NBITS-1];
                        cnt_r   <= CNT_W'(1);
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r < NBITS_C) begin
                        sout_r  <= shreg_r[NBITS-2];
                        shreg_r <= shreg_r << 1;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end else begin
                        sout_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    sout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sout       = sout_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.load_ready = ready_r;

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter with clock enable. It is the sending end of a single-wire serial bit stream whose receiving end is a chain of enabled D flip-flops.
- Accepts one WIDTH-bit word through a valid/ready load handshake and shifts it out MSB first, one bit per enabled clock.
- Flags completion with a one-cycle done pulse.
- Sits between register-level logic and any serial capture stage in the flip-flop library.

Parameters:
- WIDTH, 8, data word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset; overrides en
- en  input  1  clock enable; 0 = hold all state and outputs
- din  input  WIDTH  parallel word to transmit
- load_valid  input  1  din is valid this cycle
- load_ready  output  1  block can accept a word (registered)
- sout  output  1  serial data out (registered); idle level 0
- busy  output  1  frame bits on sout (registered)
- done  output  1  one-cycle pulse after the last bit (registered)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset (rst=1 at posedge, regardless of en):
  - state=IDLE, shift register=0, bit counter=0
  - sout=0, busy=0, done=0, load_ready=1
- en=0 at posedge with rst=0: state, counter, shift register and all outputs hold their values. An enable gap stretches the current bit and also stretches the done pulse.
- FSM states: IDLE, SHIFT, DONE. All transitions below happen only at posedges with en=1 and rst=0.
- IDLE:
  - load_ready=1, busy=0, done=0, sout=0.
  - Accept condition: load_valid=1 && load_ready=1 && en=1 at posedge k.
  - On accept: shreg<=din, sout<=din[WIDTH-1], counter<=1, busy<=1, load_ready<=0, state<=SHIFT.
  - load_valid=0: stay in IDLE.
- SHIFT:
  - On each enabled edge with counter<NBITS: sout<=next bit (MSB first), counter increments.
  - NBITS=WIDTH.
  - Bit j (din[WIDTH-1-j]) is on sout from enabled edge k+j until enabled edge k+j+1, for j=0..NBITS-1.
  - load_valid is ignored and din is not sampled.
- Exit from SHIFT at enabled edge k+NBITS: state<=DONE, sout<=0, busy<=0, done<=1.
- DONE:
  - At the next enabled edge: done<=0, load_ready<=1, state<=IDLE.
  - The earliest next accept is the enabled edge after that, so back-to-back frames have exactly 2 idle cycles between frames when en=1 continuously.
- Latency with en=1 continuously:
  - First bit appears 1 cycle after accept.
  - done is high in cycle NBITS+1 after accept.
  - load_ready returns NBITS+2 cycles after accept.
- Counter width is $clog2(NBITS+1); no wrap-around is permitted.
- Reset mid-frame: the frame is abandoned immediately at that edge. Outputs go to their reset values and no done pulse is produced.
- load_valid held high continuously: the word is accepted once per frame, only when load_ready=1.
- X on din while not accepting must not propagate to any output.

Optional Feature:
- Macro: PISO_PARITY_EN
- Defined:
  - After the WIDTH data bits, one even-parity bit is sent: ^din of the accepted word.
  - NBITS=WIDTH+1.
  - done and the DONE state follow the parity bit.
  - The parity bit is computed at accept, from the captured word.
- Undefined: NBITS=WIDTH. No parity logic and no extra bit.

Test Plan:
- Reset: rst=1 for 2 cycles with en=0 and load_valid=1 -> after the edge, sout=0, busy=0, done=0, load_ready=1. No word is accepted.
- Single frame: WIDTH=8, din=8'hA5, load_valid=1 for one cycle, en=1 -> sout=1,0,1,0,0,1,0,1 on cycles 1..8, busy=1 on cycles 1..8, done=1 on cycle 9 only, load_ready=1 from cycle 10.
- Load while busy: din=8'h3C accepted, then din=8'hFF with load_valid=1 on cycles 2..6 -> serial stream is exactly 0,0,1,1,1,1,0,0. The FF word is accepted only at cycle 10.
- Enable gap: din=8'hC3, en=0 during cycles 3..5 -> the bit on sout at cycle 3 (1'b0) is held for 4 cycles. The full sequence is otherwise 1,1,0,0,0,0,1,1 and done is delayed by 3 cycles.
- Reset mid-frame: din=8'hF0, rst=1 at cycle 4 -> from cycle 5, sout=0, busy=0, no done pulse, load_ready=1. A fresh 8'h81 frame then transmits 1,0,0,0,0,0,0,1.
- Parity (PISO_PARITY_EN defined):
  - din=8'h07 -> 9 bits 0,0,0,0,0,1,1,1, then parity 1. done is on cycle 10.
  - din=8'h03 -> parity bit 0.
